// File: rtl/spi_ram_pkg.sv
// Shared command encoding and default widths for the SPI-attached burst RAM.
package spi_ram_pkg;

    typedef logic [1:0] cmd_t;

    localparam cmd_t CMD_WR_ADDR = 2'b00;
    localparam cmd_t CMD_WR_DATA = 2'b01;
    localparam cmd_t CMD_RD_ADDR = 2'b10;
    localparam cmd_t CMD_RD_DATA = 2'b11;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_MEM_DEPTH = 256;

endpackage

// File: rtl/sp_ram_array.sv
// Single-port RAM with registered read and no reset, shaped for block-RAM inference.
module sp_ram_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_burst_ram.sv
// Command decoder for the SPI slave: independent write/read pointers with optional
// burst auto-increment, address range checking, and a read-data strobe.
module spi_burst_ram
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W+1:0] din,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    cmd_t              cmd;
    logic [DATA_W-1:0] payload;
    logic [ADDR_W-1:0] load_addr;
    logic              load_ok;

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic              tx_valid_reg, tx_valid_next;
    logic              addr_err_reg, addr_err_next;
    logic [DATA_W-1:0] dout_hold_reg;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    assign cmd       = din[DATA_W+1:DATA_W];
    assign payload   = din[DATA_W-1:0];
    assign load_addr = payload[ADDR_W-1:0];

    // A full power-of-two memory can never see an out-of-range load.
    generate
        if (MEM_DEPTH >= (1 << ADDR_W)) begin : g_full_range
            assign load_ok = 1'b1;
        end else begin : g_range_check
            localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);
            assign load_ok = ({1'b0, load_addr} < DEPTH_L);
        end
    endgenerate

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        tx_valid_next = 1'b0;
        addr_err_next = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    if (load_ok) wr_ptr_next = load_addr;
                    else         addr_err_next = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (AUTO_INC != 0) wr_ptr_next = ptr_inc(wr_ptr_reg);
                end
                CMD_RD_ADDR: begin
                    if (load_ok) rd_ptr_next = load_addr;
                    else         addr_err_next = 1'b1;
                end
                default: begin
                    tx_valid_next = 1'b1;
                    if (AUTO_INC != 0) rd_ptr_next = ptr_inc(rd_ptr_reg);
                end
            endcase
        end
    end

    // Reset must also suppress a write presented in the same cycle.
    assign mem_we   = rst_n && rx_valid && (cmd == CMD_WR_DATA);
    assign mem_addr = (cmd == CMD_WR_DATA) ? wr_ptr_reg : rd_ptr_reg;

    sp_ram_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (payload),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            tx_valid_reg  <= 1'b0;
            addr_err_reg  <= 1'b0;
            dout_hold_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            tx_valid_reg <= tx_valid_next;
            addr_err_reg <= addr_err_next;
            if (tx_valid_reg) dout_hold_reg <= mem_rdata;
        end
    end

    // RAM output is live during the strobe cycle; afterwards the captured copy holds it.
    assign dout     = tx_valid_reg ? mem_rdata : dout_hold_reg;
    assign tx_valid = tx_valid_reg;
    assign addr_err = addr_err_reg;

endmodule

// File: tb/tb_spi_burst_ram.sv
// Directed bench for spi_burst_ram: default, reduced-depth and wide/static-pointer variants.
module tb_spi_burst_ram;
    import spi_ram_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [9:0]  din_a, din_b;
    logic [17:0] din_c;
    logic        rx_valid_a, rx_valid_b, rx_valid_c;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_c;
    logic        tx_valid_a, tx_valid_b, tx_valid_c;
    logic        addr_err_a, addr_err_b, addr_err_c;

    always #5 clk = ~clk;

    spi_burst_ram u_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .rx_valid(rx_valid_a),
        .dout(dout_a), .tx_valid(tx_valid_a), .addr_err(addr_err_a)
    );

    spi_burst_ram #(.MEM_DEPTH(200)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .rx_valid(rx_valid_b),
        .dout(dout_b), .tx_valid(tx_valid_b), .addr_err(addr_err_b)
    );

    spi_burst_ram #(.DATA_W(16), .ADDR_W(10), .MEM_DEPTH(1024), .AUTO_INC(0)) u_c (
        .clk(clk), .rst_n(rst_n), .din(din_c), .rx_valid(rx_valid_c),
        .dout(dout_c), .tx_valid(tx_valid_c), .addr_err(addr_err_c)
    );

    // Each issue task presents one command for one edge and returns at the next
    // falling edge, where that command's registered results are visible.
    task automatic issue_a(input cmd_t c, input logic [7:0] p);
        din_a = {c, p}; rx_valid_a = 1'b1;
        @(negedge clk);
        rx_valid_a = 1'b0;
        $display("txn a cmd=%0d payload=%h dout=%h tx_valid=%b addr_err=%b", c, p, dout_a, tx_valid_a, addr_err_a);
    endtask

    task automatic issue_b(input cmd_t c, input logic [7:0] p);
        din_b = {c, p}; rx_valid_b = 1'b1;
        @(negedge clk);
        rx_valid_b = 1'b0;
        $display("txn b cmd=%0d payload=%h dout=%h tx_valid=%b addr_err=%b", c, p, dout_b, tx_valid_b, addr_err_b);
    endtask

    task automatic issue_c(input cmd_t c, input logic [15:0] p);
        din_c = {c, p}; rx_valid_c = 1'b1;
        @(negedge clk);
        rx_valid_c = 1'b0;
        $display("txn c cmd=%0d payload=%h dout=%h tx_valid=%b addr_err=%b", c, p, dout_c, tx_valid_c, addr_err_c);
    endtask

    task automatic test_reset;
        checks++; if (dout_a !== 8'h00) begin errors++; $display("FAIL reset_dout_a got %h want 00", dout_a); end
        checks++; if (tx_valid_a !== 1'b0) begin errors++; $display("FAIL reset_tx_a got %b want 0", tx_valid_a); end
        checks++; if (addr_err_a !== 1'b0) begin errors++; $display("FAIL reset_err_a got %b want 0", addr_err_a); end
        checks++; if (dout_b !== 8'h00 || tx_valid_b !== 1'b0 || addr_err_b !== 1'b0) begin
            errors++; $display("FAIL reset_b got dout=%h tx=%b err=%b want 00 0 0", dout_b, tx_valid_b, addr_err_b); end
        checks++; if (dout_c !== 16'h0000 || tx_valid_c !== 1'b0 || addr_err_c !== 1'b0) begin
            errors++; $display("FAIL reset_c got dout=%h tx=%b err=%b want 0000 0 0", dout_c, tx_valid_c, addr_err_c); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++; if (dout_a !== 8'h00 || tx_valid_a !== 1'b0 || addr_err_a !== 1'b0) begin
                errors++; $display("FAIL idle_%0d got dout=%h tx=%b err=%b want 00 0 0", i, dout_a, tx_valid_a, addr_err_a); end
        end
    endtask

    task automatic test_single;
        issue_a(CMD_WR_ADDR, 8'h12);
        checks++; if (addr_err_a !== 1'b0) begin errors++; $display("FAIL single_wraddr_err got %b want 0", addr_err_a); end
        issue_a(CMD_WR_DATA, 8'hA5);
        issue_a(CMD_RD_ADDR, 8'h12);
        checks++; if (tx_valid_a !== 1'b0 || dout_a !== 8'h00) begin
            errors++; $display("FAIL single_rdaddr got tx=%b dout=%h want 0 00", tx_valid_a, dout_a); end
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'hA5) begin errors++; $display("FAIL single_dout got %h want a5", dout_a); end
        checks++; if (tx_valid_a !== 1'b1) begin errors++; $display("FAIL single_tx got %b want 1", tx_valid_a); end
        @(negedge clk);
        checks++; if (tx_valid_a !== 1'b0 || dout_a !== 8'hA5) begin
            errors++; $display("FAIL single_hold got tx=%b dout=%h want 0 a5", tx_valid_a, dout_a); end
    endtask

    task automatic test_burst_wrap;
        logic [7:0] exp [3];
        exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33;
        issue_a(CMD_WR_ADDR, 8'hFE);
        for (int i = 0; i < 3; i++) issue_a(CMD_WR_DATA, exp[i]);
        checks++; if (addr_err_a !== 1'b0) begin errors++; $display("FAIL burst_wrap_err got %b want 0", addr_err_a); end
        issue_a(CMD_RD_ADDR, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            issue_a(CMD_RD_DATA, 8'h00);
            checks++; if (dout_a !== exp[i] || tx_valid_a !== 1'b1) begin
                errors++; $display("FAIL burst_rd_%0d got dout=%h tx=%b want %h 1", i, dout_a, tx_valid_a, exp[i]); end
        end
        @(negedge clk);
        checks++; if (tx_valid_a !== 1'b0 || dout_a !== 8'h33) begin
            errors++; $display("FAIL burst_end got tx=%b dout=%h want 0 33", tx_valid_a, dout_a); end
        issue_a(CMD_RD_ADDR, 8'h00);
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'h33) begin errors++; $display("FAIL burst_addr0 got %h want 33", dout_a); end
    endtask

    task automatic test_range;
        issue_b(CMD_WR_ADDR, 8'h10);
        checks++; if (addr_err_b !== 1'b0) begin errors++; $display("FAIL range_ok_err got %b want 0", addr_err_b); end
        issue_b(CMD_WR_ADDR, 8'hC8);
        checks++; if (addr_err_b !== 1'b1) begin errors++; $display("FAIL range_bad_err got %b want 1", addr_err_b); end
        @(negedge clk);
        checks++; if (addr_err_b !== 1'b0) begin errors++; $display("FAIL range_err_pulse got %b want 0", addr_err_b); end
        issue_b(CMD_WR_DATA, 8'h5A);
        issue_b(CMD_RD_ADDR, 8'h10);
        issue_b(CMD_RD_DATA, 8'h00);
        checks++; if (dout_b !== 8'h5A) begin errors++; $display("FAIL range_readback got %h want 5a", dout_b); end
        issue_b(CMD_RD_ADDR, 8'hC7);
        checks++; if (addr_err_b !== 1'b0) begin errors++; $display("FAIL range_last_err got %b want 0", addr_err_b); end
        issue_b(CMD_WR_ADDR, 8'hC7);
        issue_b(CMD_WR_DATA, 8'h77);
        issue_b(CMD_WR_DATA, 8'h88);
        issue_b(CMD_RD_DATA, 8'h00);
        checks++; if (dout_b !== 8'h77) begin errors++; $display("FAIL range_last_data got %h want 77", dout_b); end
        issue_b(CMD_RD_DATA, 8'h00);
        checks++; if (dout_b !== 8'h88) begin errors++; $display("FAIL range_wrap_data got %h want 88", dout_b); end
    endtask

    task automatic test_back_to_back;
        issue_a(CMD_WR_ADDR, 8'h40);
        issue_a(CMD_RD_ADDR, 8'h40);
        issue_a(CMD_WR_DATA, 8'h3C);
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'h3C) begin errors++; $display("FAIL raw_hazard got %h want 3c", dout_a); end
        issue_a(CMD_RD_ADDR, 8'h80);
        issue_a(CMD_WR_DATA, 8'h99);
        issue_a(CMD_RD_ADDR, 8'h41);
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'h99) begin errors++; $display("FAIL ptr_independent got %h want 99", dout_a); end
    endtask

    task automatic test_reset_mid_burst;
        issue_a(CMD_WR_ADDR, 8'h50);
        issue_a(CMD_WR_DATA, 8'h01);
        issue_a(CMD_RD_ADDR, 8'h50);
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'h01) begin errors++; $display("FAIL pre_reset_dout got %h want 01", dout_a); end
        rst_n = 1'b0;
        issue_a(CMD_RD_DATA, 8'h00);
        rst_n = 1'b1;
        checks++; if (dout_a !== 8'h00 || tx_valid_a !== 1'b0) begin
            errors++; $display("FAIL mid_reset got dout=%h tx=%b want 00 0", dout_a, tx_valid_a); end
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'h33) begin errors++; $display("FAIL rd_ptr_after_reset got %h want 33", dout_a); end
        issue_a(CMD_WR_DATA, 8'h5D);
        issue_a(CMD_RD_ADDR, 8'h00);
        issue_a(CMD_RD_DATA, 8'h00);
        checks++; if (dout_a !== 8'h5D) begin errors++; $display("FAIL wr_ptr_after_reset got %h want 5d", dout_a); end
    endtask

    task automatic test_wide;
        issue_c(CMD_WR_ADDR, 16'h03FF);
        checks++; if (addr_err_c !== 1'b0) begin errors++; $display("FAIL wide_addr_err got %b want 0", addr_err_c); end
        issue_c(CMD_WR_DATA, 16'hBEEF);
        issue_c(CMD_RD_ADDR, 16'h03FF);
        issue_c(CMD_RD_DATA, 16'h0000);
        checks++; if (dout_c !== 16'hBEEF || tx_valid_c !== 1'b1) begin
            errors++; $display("FAIL wide_rd0 got dout=%h tx=%b want beef 1", dout_c, tx_valid_c); end
        issue_c(CMD_RD_DATA, 16'h0000);
        checks++; if (dout_c !== 16'hBEEF) begin errors++; $display("FAIL wide_rd1 got %h want beef", dout_c); end
        issue_c(CMD_WR_DATA, 16'h1234);
        issue_c(CMD_RD_DATA, 16'h0000);
        checks++; if (dout_c !== 16'h1234) begin errors++; $display("FAIL wide_static_wr got %h want 1234", dout_c); end
    endtask

    initial begin
        rst_n = 1'b0;
        rx_valid_a = 1'b0; rx_valid_b = 1'b0; rx_valid_c = 1'b0;
        din_a = '0; din_b = '0; din_c = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_single();
        test_burst_wrap();
        test_range();
        test_back_to_back();
        test_reset_mid_burst();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_burst_ram.md
# spi_burst_ram

Parametrised command-decoded single-port RAM behind the SPI slave front end. Consumes framed words (2-bit command + payload) from the SPI receive path, holds independent write and read address pointers with optional auto-increment for burst transfers, and returns read data to the SPI transmit path with a one-cycle `tx_valid` strobe. It generalises the 8-bit/256-entry command RAM in data width, address width and depth, and adds burst addressing and address range checking.

## Interface
- `DATA_W`, 8, width of a stored word and of `dout`
- `ADDR_W`, 8, address pointer width; must satisfy `ADDR_W <= DATA_W`
- `MEM_DEPTH`, 256, number of words; must satisfy `MEM_DEPTH <= 2**ADDR_W`
- `AUTO_INC`, 1, 1 = pointer post-increments after each data command; 0 = pointers static
- `clk` input 1: clock, all state on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `din` input `DATA_W+2`: `din[DATA_W+1:DATA_W]` = command, `din[DATA_W-1:0]` = payload
- `rx_valid` input 1: `din` valid this cycle; exactly one command per asserted cycle
- `dout` output `DATA_W`: read data, held until next read
- `tx_valid` output 1: one-cycle pulse, `dout` newly valid
- `addr_err` output 1: one-cycle pulse, rejected address load

## Operation
- Commands, decoded only when `rx_valid` = 1:
  - 00 WR_ADDR: `wr_ptr <= payload[ADDR_W-1:0]`
  - 01 WR_DATA: `mem[wr_ptr] <= payload`; if `AUTO_INC`, then `wr_ptr <= wr_ptr+1`
  - 10 RD_ADDR: `rd_ptr <= payload[ADDR_W-1:0]`; no change to `dout`
  - 11 RD_DATA: `dout <= mem[rd_ptr]`; `tx_valid` pulses; if `AUTO_INC`, then `rd_ptr <= rd_ptr+1`
- Payload bits above `ADDR_W` are ignored for address commands.
- Range check on WR_ADDR/RD_ADDR:
  - Loaded value >= `MEM_DEPTH`: pointer unchanged, `addr_err` pulses for one cycle.
  - The check is constant-false when `MEM_DEPTH == 2**ADDR_W`.
- Pointer wrap: increment from `MEM_DEPTH-1` goes to 0, with no error. Pointers can never hold an out-of-range value.
- The write and read pointers are independent; loading one never alters the other.
- `rx_valid` = 0: no state changes, apart from `tx_valid` and `addr_err` returning to 0.
- Memory contents are not reset and are undefined until written; behaviour at reset is otherwise unaffected.

## Timing
- Reset (`rst_n` = 0 at an edge): `dout` = 0, `tx_valid` = 0, `addr_err` = 0, `wr_ptr` = 0, `rd_ptr` = 0.
  - Reset overrides any command presented in the same cycle.
  - Reset mid-burst discards the pointers; the burst must be restarted with an address command.
- Command latency, measured from the edge sampling `rx_valid` = 1:
  - Pointer update, memory write, `dout`, `tx_valid` and `addr_err` are all registered at that edge and visible in the following cycle.
- `tx_valid` is high for exactly one cycle per RD_DATA. Back-to-back RD_DATA gives `tx_valid` high continuously, with `dout` stepping each cycle.
- Read-after-write hazard: WR_DATA to address A at edge n, then RD_DATA of A at edge n+1, returns the new data. No bypass is needed because each cycle carries at most one command.
- Single port: at most one memory access per cycle by construction.
- No backpressure: the SPI side must not issue RD_DATA faster than it can shift `dout` out.

## Structure
- Package `spi_ram_pkg`:
  - command localparams `CMD_WR_ADDR`=2'b00, `CMD_WR_DATA`=2'b01, `CMD_RD_ADDR`=2'b10, `CMD_RD_DATA`=2'b11
  - `cmd_t` typedef
  - shared default widths
- Sub-module `sp_ram_array`:
  - parameters `DATA_W`, `ADDR_W`, `MEM_DEPTH`
  - ports `clk`, `we`, `addr`, `wdata`, registered `rdata`
  - no reset
- The top level holds the decode, pointers, range check, increment/wrap logic and output flags.

## Test plan
- Reset then idle: after reset, `dout`=0, `tx_valid`=0, `addr_err`=0; 10 cycles with `rx_valid`=0 leave all of them unchanged.
- Single access, default params: WR_ADDR 0x12, WR_DATA 0xA5, RD_ADDR 0x12, RD_DATA → `dout`=0xA5, `tx_valid` high for one cycle.
- Burst with wrap, `AUTO_INC`=1:
  - WR_ADDR 0xFE, then WR_DATA 0x11/0x22/0x33 → addresses 0xFE, 0xFF, 0x00.
  - RD_ADDR 0xFE plus 3× back-to-back RD_DATA → `dout` 0x11, 0x22, 0x33; `tx_valid` high for 3 cycles.
- Range error, `MEM_DEPTH`=200:
  - WR_ADDR 0x10, then WR_ADDR 0xC8 → `addr_err` pulses once.
  - A following WR_DATA 0x5A lands at 0x10, confirmed by readback.
- Independence, back-to-back, and reset mid-burst:
  - WR_DATA to A immediately followed by RD_DATA of A → new data.
  - Loading `rd_ptr` leaves `wr_ptr` unchanged.
  - `rst_n` low mid-burst → both pointers 0 and `dout`=0 on the next cycle.
- Wide variant, `DATA_W`=16, `ADDR_W`=10, `MEM_DEPTH`=1024, `AUTO_INC`=0: WR 0x3FF ← 0xBEEF; two RD_DATA both return 0xBEEF (no increment).
